tbu_reorder_buf: RTL and testbench

- Downstream stage of the Viterbi traceback unit. It consumes the decoded bits the traceback emits, which arrive in reverse time order, one bit per cycle, qualified by the traceback write-enable.
- It buffers each traceback block in a ping-pong pair of bit banks and replays it last-in-first-out, so decoded bits leave in correct time order.
- Its output feeds the decoder output/FIFO stage.

---
 rtl/tbu_reorder_buf.sv | 153 +++++++++++++++
 tb/tb_tbu_reorder_buf.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbu_reorder_buf.sv
// Traceback reorder buffer: collects reverse-order decoded bits into a
// ping-pong bank pair and replays each block LIFO so bits leave in time order.
module tbu_reorder_buf #(
   parameter int unsigned BLOCK_LEN = 64,
   parameter int unsigned AW        = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic d_in,
   input  logic wr_en,
   output logic d_out,
   output logic d_out_valid,
   output logic d_out_first,
   output logic d_out_last,
   output logic overflow
);

   typedef enum logic {W_IDLE = 1'b0, W_FILL  = 1'b1} w_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} r_state_e;

   localparam logic [AW-1:0] LAST_ADDR = AW'(BLOCK_LEN - 1);

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic          rfirst_q, rfirst_d;
   logic          dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          first_q, first_d;
   logic          last_q, last_d;
   logic          ovf_q, ovf_d;

   logic [BLOCK_LEN-1:0] mem_q [2];
   logic                 mem_we_c;
   logic                 rd_done_c;
   logic                 comp_full_c;
   logic                 comp_part_c;

   // Next-state logic for both write and read sides, including block hand-off
   always_comb begin
      w_state_d   = w_state_q;
      r_state_d   = r_state_q;
      wcnt_d      = wcnt_q;
      rptr_d      = rptr_q;
      wbank_d     = wbank_q;
      rbank_d     = rbank_q;
      rfirst_d    = rfirst_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      first_d     = 1'b0;
      last_d      = 1'b0;
      ovf_d       = ovf_q;
      mem_we_c    = 1'b0;
      rd_done_c   = (r_state_q == R_DRAIN) && (rptr_q == '0);
      comp_full_c = wr_en && (wcnt_q == LAST_ADDR);
      comp_part_c = !wr_en && (w_state_q == W_FILL);

      if (!enable) begin
         w_state_d = W_IDLE;
         r_state_d = R_IDLE;
         wcnt_d    = '0;
         rptr_d    = '0;
         wbank_d   = 1'b0;
         rbank_d   = 1'b0;
         rfirst_d  = 1'b0;
         dout_d    = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         // Drain one bit per cycle, highest address first
         if (r_state_q == R_DRAIN) begin
            dout_d   = mem_q[rbank_q][rptr_q];
            valid_d  = 1'b1;
            first_d  = rfirst_q;
            last_d   = rd_done_c;
            rfirst_d = 1'b0;
            rptr_d   = rptr_q - AW'(1);
            if (rd_done_c) begin
               r_state_d = R_IDLE;
            end
         end

         if (wr_en) begin
            mem_we_c  = 1'b1;
            wcnt_d    = wcnt_q + AW'(1);
            w_state_d = W_FILL;
         end

         // A finished block either moves to the reader or is dropped
         if (comp_full_c || comp_part_c) begin
            wcnt_d    = '0;
            w_state_d = W_IDLE;
            if ((r_state_q == R_IDLE) || rd_done_c) begin
               rbank_d   = wbank_q;
               rptr_d    = comp_full_c ? LAST_ADDR : (wcnt_q - AW'(1));
               r_state_d = R_DRAIN;
               rfirst_d  = 1'b1;
               wbank_d   = ~wbank_q;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         wcnt_q    <= '0;
         rptr_q    <= '0;
         wbank_q   <= 1'b0;
         rbank_q   <= 1'b0;
         rfirst_q  <= 1'b0;
         dout_q    <= 1'b0;
         valid_q   <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         wcnt_q    <= wcnt_d;
         rptr_q    <= rptr_d;
         wbank_q   <= wbank_d;
         rbank_q   <= rbank_d;
         rfirst_q  <= rfirst_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         first_q   <= first_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
      end
   end

   // Bank storage; contents need no reset since the reader never sees stale bits
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[wbank_q][wcnt_q] <= d_in;
      end
   end

   assign d_out       = dout_q;
   assign d_out_valid = valid_q;
   assign d_out_first = first_q;
   assign d_out_last  = last_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_tbu_reorder_buf.sv
// Bench for tbu_reorder_buf with BLOCK_LEN=8: scoreboard of expected output bits.
module tb_tbu_reorder_buf;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic d_in;
   logic wr_en;
   logic d_out;
   logic d_out_valid;
   logic d_out_first;
   logic d_out_last;
   logic overflow;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [2:0] exp_q[$];
   logic [2:0] obs_q[$];
   int         obs_cyc[$];

   tbu_reorder_buf #(.BLOCK_LEN(8), .AW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .d_in       (d_in),
      .wr_en      (wr_en),
      .d_out      (d_out),
      .d_out_valid(d_out_valid),
      .d_out_first(d_out_first),
      .d_out_last (d_out_last),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every valid output beat as {d_out, first, last}
   always @(posedge clk) begin
      #1;
      if (d_out_valid === 1'b1) begin
         obs_q.push_back({d_out, d_out_first, d_out_last});
         obs_cyc.push_back(cyc);
      end
   end

   // Expected LIFO replay of one block; bits[i] is the i-th bit written
   task automatic push_exp(input logic [15:0] bits, input int n);
      for (int j = 0; j < n; j++)
         exp_q.push_back({bits[n-1-j], (j == 0), (j == n-1)});
   endtask

   // Write n bits back-to-back, then drop wr_en at the following negedge
   task automatic drive_bits(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_en = 1'b1;
         d_in  = bits[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
      d_in  = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      int c = 0;
      while (obs_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset;
      rst = 1'b0; enable = 1'b1; wr_en = 1'b0; d_in = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({d_out, d_out_valid, d_out_first, d_out_last, overflow} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {d_out, d_out_valid, d_out_first, d_out_last, overflow});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_block;
      bit ok;
      logic [2:0] e, o;
      int c0, c1;
      push_exp(16'h004D, 8);
      drive_bits(16'h004D, 8);
      vectors++;
      if (d_out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL full_latency_early: valid=%b want 0 one edge after completion", d_out_valid);
      end
      @(negedge clk);
      vectors++;
      if ({d_out_valid, d_out_first} !== 2'b11) begin
         miscompares++;
         $display("FAIL full_latency: valid/first=%b want 11 two edges after completion",
                  {d_out_valid, d_out_first});
      end
      wait_obs(8, 30, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL full_timeout: got %0d beats want 8", obs_q.size());
      end
      c0 = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
      c1 = (obs_cyc.size() > 7) ? obs_cyc[7] : 0;
      vectors++;
      if (c1 - c0 != 7) begin
         miscompares++;
         $display("FAIL full_contiguous: span %0d want 7", c1 - c0);
      end
      for (int j = 0; j < 8 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL full_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL full_overflow: got %b want 0", overflow);
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_partial;
      bit ok;
      logic [2:0] e, o;
      push_exp(16'h0003, 3);
      drive_bits(16'h0003, 3);
      wait_obs(3, 20, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL partial_timeout: got %0d beats want 3", obs_q.size());
      end
      for (int j = 0; j < 3 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL partial_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_back_to_back;
      bit ok;
      logic [2:0] e, o;
      int c0, c1;
      push_exp(16'h00F0, 8);
      push_exp(16'h0001, 8);
      drive_bits(16'h01F0, 16);
      wait_obs(16, 40, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL b2b_timeout: got %0d beats want 16", obs_q.size());
      end
      c0 = (obs_cyc.size() > 0)  ? obs_cyc[0]  : 0;
      c1 = (obs_cyc.size() > 15) ? obs_cyc[15] : 0;
      vectors++;
      if (c1 - c0 != 15) begin
         miscompares++;
         $display("FAIL b2b_contiguous: span %0d want 15", c1 - c0);
      end
      for (int j = 0; j < 16 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL b2b_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_overflow: got %b want 0", overflow);
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_overflow;
      bit ok;
      logic [2:0] e, o;
      push_exp(16'h008B, 8);
      drive_bits(16'h008B, 8);
      drive_bits(16'h0001, 1);
      wait_obs(8, 30, ok);
      repeat (6) @(negedge clk);
      vectors++;
      if (obs_q.size() != 8) begin
         miscompares++;
         $display("FAIL ovf_beat_count: got %0d beats want 8", obs_q.size());
      end
      for (int j = 0; j < 8 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ovf_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_flag: got %b want 1", overflow);
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
      push_exp(16'h0001, 2);
      drive_bits(16'h0001, 2);
      wait_obs(2, 20, ok);
      repeat (3) @(negedge clk);
      vectors++;
      if (obs_q.size() != 2) begin
         miscompares++;
         $display("FAIL ovf_next_count: got %0d beats want 2", obs_q.size());
      end
      for (int j = 0; j < 2 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc.pop_front());
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ovf_next_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got %b want 1", overflow);
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_single;
      bit ok;
      logic [2:0] e, o;
      push_exp(16'h0001, 1);
      drive_bits(16'h0001, 1);
      wait_obs(1, 20, ok);
      repeat (3) @(negedge clk);
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL single_count: got %0d beats want 1", obs_q.size());
      end
      if (obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL single_bit: got d/f/l=%b want %b", o, e);
         end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   task automatic test_clear;
      bit ok;
      logic [2:0] e, o;
      int c;
      push_exp(16'h00B6, 8);
      drive_bits(16'h00B6, 8);
      wait_obs(4, 30, ok);
      enable = 1'b0;
      @(negedge clk);
      vectors++;
      if ({d_out_valid, d_out_first, d_out_last, overflow} !== 4'b0) begin
         miscompares++;
         $display("FAIL clear_outputs: valid/first/last/ovf=%b want 0000",
                  {d_out_valid, d_out_first, d_out_last, overflow});
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (obs_q.size() != 4) begin
         miscompares++;
         $display("FAIL clear_count: got %0d beats want 4", obs_q.size());
      end
      for (int j = 0; j < 4 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL clear_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
      enable = 1'b1;
      @(negedge clk);
      // Provoke overflow again, then pull async reset mid-drain
      drive_bits(16'h00FF, 8);
      drive_bits(16'h0001, 1);
      c = 0;
      while (overflow !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({d_out, d_out_valid, d_out_first, d_out_last, overflow} !== 5'b0) begin
         miscompares++;
         $display("FAIL async_reset: got %b want 00000",
                  {d_out, d_out_valid, d_out_first, d_out_last, overflow});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
      push_exp(16'h0035, 8);
      drive_bits(16'h0035, 8);
      wait_obs(8, 30, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL reenable_timeout: got %0d beats want 8", obs_q.size());
      end
      for (int j = 0; j < 8 && obs_q.size() > 0; j++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reenable_bit%0d: got d/f/l=%b want %b", j, o, e);
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reenable_overflow: got %b want 0", overflow);
      end
      exp_q.delete(); obs_q.delete(); obs_cyc.delete();
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_partial();
      test_back_to_back();
      test_overflow();
      test_single();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
